// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the multi-cycle RV32-subset sequencer:
//   - state_t    : sequencer state encoding
//   - OP_*       : IR[6:0] opcodes the sequencer recognises
//   - ALUOP_*    : AluOp strobe encodings
//   - SRCB_*     : AluSrcB strobe encodings
//   - is_mem_wait_state() : states that own the memory port and may stall
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC_R,
    EXEC_I,
    ALUWB,
    BRANCH,
    ILLEGAL,
    FAULT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // States that drive a memory access and wait on mem_ready.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
//   Counts consecutive stalled memory cycles and flags when the count has
//   reached MEM_WAIT_MAX.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     i_clear     : zero the count (takes priority over i_cnt_en)
//     i_cnt_en    : add one this cycle (saturates at MEM_WAIT_MAX)
//     o_terminal  : count == MEM_WAIT_MAX
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_cnt_en,
  output logic o_terminal
);

  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] MAX_VAL = CW'(MEM_WAIT_MAX);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_cnt_en && (r_count != MAX_VAL)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_terminal = (r_count == MAX_VAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for an RV32 subset (R-type, I-type ALU, LW, SW,
//   BEQ) sharing one ALU and one unified instruction/data memory port.
//   Strobes are a combinational decode of the current state (FETCH also
//   looks at mem_ready) and are all forced low while rst is high.
//
//   Optional feature macro: MULTICYCLE_PERF_CNT_EN
//     defined   -> cycle_cnt / instret_cnt performance counters
//     undefined -> both counter ports tied to 0
//
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     opcode            : IR[6:0], valid from DECODE onward
//     zero              : ALU zero flag (gated into PC load by the datapath)
//     mem_ready         : memory completes the current access this cycle
//     PcWrite/PcWriteCond/PcSource, IorD, IrWrite, MemRead, MemWrite,
//     MemtoReg, RegWrite, AluSrcA, AluSrcB, AluOp : datapath strobes
//     IllegalOp         : one-cycle pulse on an unsupported opcode
//     BusErr            : sticky memory-timeout flag
//     cycle_cnt         : cycles since reset (outside FAULT)
//     instret_cnt       : retired instructions
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PcWrite,
  output logic             PcWriteCond,
  output logic             PcSource,
  output logic             IorD,
  output logic             IrWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluOp,
  output logic             IllegalOp,
  output logic             BusErr,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t r_state;
  state_t w_state_next;
  logic   r_bus_err;
  logic   w_hold;
  logic   w_terminal;
  logic   w_unused_zero;

  // The branch decision is made in the datapath (PcWriteCond & zero).
  assign w_unused_zero = zero;

  // A memory state is "holding" when it waits on the bus. The timer is kept
  // at zero in every other cycle, so each fresh access starts from zero.
  assign w_hold = is_mem_wait_state(r_state) && !mem_ready;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_hold),
    .i_cnt_en  (w_hold),
    .o_terminal(w_terminal)
  );

  // Next-state logic. In the memory states mem_ready is checked before the
  // timeout so a completion on the terminal cycle still succeeds.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: begin
        if (mem_ready)       w_state_next = DECODE;
        else if (w_terminal) w_state_next = FAULT;
      end
      DECODE: begin
        case (opcode)
          OP_R:              w_state_next = EXEC_R;
          OP_I:              w_state_next = EXEC_I;
          OP_LOAD, OP_STORE: w_state_next = MEMADR;
          OP_BRANCH:         w_state_next = BRANCH;
          default:           w_state_next = ILLEGAL;
        endcase
      end
      EXEC_R:  w_state_next = ALUWB;
      EXEC_I:  w_state_next = ALUWB;
      ALUWB:   w_state_next = FETCH;
      MEMADR: begin
        if (opcode == OP_LOAD)       w_state_next = MEMRD;
        else if (opcode == OP_STORE) w_state_next = MEMWR;
        else                         w_state_next = ILLEGAL;
      end
      MEMRD: begin
        if (mem_ready)       w_state_next = MEMWB;
        else if (w_terminal) w_state_next = FAULT;
      end
      MEMWB:   w_state_next = FETCH;
      MEMWR: begin
        if (mem_ready)       w_state_next = FETCH;
        else if (w_terminal) w_state_next = FAULT;
      end
      BRANCH:  w_state_next = FETCH;
      ILLEGAL: w_state_next = FETCH;
      FAULT:   w_state_next = FAULT;
      default: w_state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bus_err <= r_bus_err | (w_state_next == FAULT);
    end
  end

  // Strobe decode.
  always_comb begin
    PcWrite     = 1'b0;
    PcWriteCond = 1'b0;
    PcSource    = 1'b0;
    IorD        = 1'b0;
    IrWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = SRCB_RS2;
    AluOp       = ALUOP_ADD;
    IllegalOp   = 1'b0;
    BusErr      = 1'b0;
    if (!rst) begin
      BusErr = r_bus_err;
      case (r_state)
        FETCH: begin
          MemRead = 1'b1;
          AluSrcB = SRCB_FOUR;
          // PC+4 is written back the same cycle the instruction word lands.
          IrWrite = mem_ready;
          PcWrite = mem_ready;
        end
        DECODE: begin
          AluSrcB = SRCB_BOFF;
        end
        EXEC_R: begin
          AluSrcA = 1'b1;
          AluSrcB = SRCB_RS2;
          AluOp   = ALUOP_FUNCT;
        end
        EXEC_I: begin
          AluSrcA = 1'b1;
          AluSrcB = SRCB_IMM;
          AluOp   = ALUOP_FUNCT;
        end
        ALUWB: begin
          RegWrite = 1'b1;
        end
        MEMADR: begin
          AluSrcA = 1'b1;
          AluSrcB = SRCB_IMM;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        BRANCH: begin
          AluSrcA     = 1'b1;
          AluSrcB     = SRCB_RS2;
          AluOp       = ALUOP_SUB;
          PcWriteCond = 1'b1;
          PcSource    = 1'b1;
        end
        ILLEGAL: begin
          IllegalOp = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic             w_retire;

  // An instruction retires when its last state hands back to FETCH;
  // ILLEGAL also returns to FETCH but does not count.
  assign w_retire = (w_state_next == FETCH) &&
                    ((r_state == ALUWB) || (r_state == MEMWB) ||
                     (r_state == MEMWR) || (r_state == BRANCH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != FAULT) r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
      if (w_retire)         r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. Each instruction is expanded
//   into the per-cycle list of strobe patterns it must produce (from the
//   instruction class and the number of memory stall cycles), then played
//   against the DUT one cycle at a time.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

`ifdef MULTICYCLE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       opcode = 7'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             PcWrite, PcWriteCond, PcSource, IorD, IrWrite, MemRead;
  logic             MemWrite, MemtoReg, RegWrite, AluSrcA, IllegalOp, BusErr;
  logic [1:0]       AluSrcB, AluOp;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_WAIT_MAX(15),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PcWrite    (PcWrite),
    .PcWriteCond(PcWriteCond),
    .PcSource   (PcSource),
    .IorD       (IorD),
    .IrWrite    (IrWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .AluSrcA    (AluSrcA),
    .AluSrcB    (AluSrcB),
    .AluOp      (AluOp),
    .IllegalOp  (IllegalOp),
    .BusErr     (BusErr),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  // Bundle order: PcWrite PcWriteCond PcSource IorD IrWrite MemRead MemWrite
  //               MemtoReg RegWrite AluSrcA AluSrcB[1:0] AluOp[1:0] IllegalOp BusErr
  function automatic logic [15:0] sv(input logic pcw, input logic pcwc,
                                     input logic pcs, input logic iord,
                                     input logic irw, input logic mr,
                                     input logic mw, input logic m2r,
                                     input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic ill, input logic be);
    return {pcw, pcwc, pcs, iord, irw, mr, mw, m2r, rw, asa, asb, aop, ill, be};
  endfunction

  localparam logic [15:0] V_FWAIT  = sv(0,0,0,0,0,1,0,0,0,0,2'b01,2'b00,0,0);
  localparam logic [15:0] V_FDONE  = sv(1,0,0,0,1,1,0,0,0,0,2'b01,2'b00,0,0);
  localparam logic [15:0] V_DEC    = sv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0);
  localparam logic [15:0] V_EXR    = sv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0);
  localparam logic [15:0] V_EXI    = sv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b10,0,0);
  localparam logic [15:0] V_ALUWB  = sv(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,0,0);
  localparam logic [15:0] V_MEMADR = sv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0);
  localparam logic [15:0] V_MEMRD  = sv(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,0,0);
  localparam logic [15:0] V_MEMWB  = sv(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,0,0);
  localparam logic [15:0] V_MEMWR  = sv(0,0,0,1,0,0,1,0,0,0,2'b00,2'b00,0,0);
  localparam logic [15:0] V_BR     = sv(0,1,1,0,0,0,0,0,0,1,2'b00,2'b01,0,0);
  localparam logic [15:0] V_ILL    = sv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,1,0);
  localparam logic [15:0] V_FAULT  = sv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1);
  localparam logic [15:0] V_NONE   = 16'h0000;

  logic [15:0] obs_vec;
  assign obs_vec = {PcWrite, PcWriteCond, PcSource, IorD, IrWrite, MemRead,
                    MemWrite, MemtoReg, RegWrite, AluSrcA, AluSrcB, AluOp,
                    IllegalOp, BusErr};

  int total = 0;
  int bad = 0;
  int exp_cycles = 0;
  int exp_instret = 0;
  int txn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, check, then let one rising edge pass.
  task automatic run_step(input logic rdy, input logic [15:0] exp, input string tag);
    mem_ready = rdy;
    #1;
    chk({tag, "/strobes"}, {16'd0, obs_vec}, {16'd0, exp});
    chk({tag, "/cycle_cnt"}, cycle_cnt, PERF ? 32'(exp_cycles) : 32'd0);
    chk({tag, "/instret_cnt"}, instret_cnt, PERF ? 32'(exp_instret) : 32'd0);
    if (exp != V_FAULT) exp_cycles++;
    @(negedge clk);
  endtask

  // Expand one instruction into its expected cycle list and play it.
  // max_steps < list length truncates the instruction (no retirement).
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic z, input int max_steps);
    logic        q_rdy[$];
    logic [15:0] q_exp[$];
    bit          retires;
    int          n;
    retires = 1'b1;
    for (int k = 0; k < fw; k++) begin q_rdy.push_back(1'b0); q_exp.push_back(V_FWAIT); end
    q_rdy.push_back(1'b1); q_exp.push_back(V_FDONE);
    q_rdy.push_back(1'($urandom)); q_exp.push_back(V_DEC);
    case (op)
      T_R: begin
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_EXR);
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_ALUWB);
      end
      T_I: begin
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_EXI);
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_ALUWB);
      end
      T_LW: begin
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_MEMADR);
        for (int k = 0; k < mw; k++) begin q_rdy.push_back(1'b0); q_exp.push_back(V_MEMRD); end
        q_rdy.push_back(1'b1); q_exp.push_back(V_MEMRD);
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_MEMWB);
      end
      T_SW: begin
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_MEMADR);
        for (int k = 0; k < mw; k++) begin q_rdy.push_back(1'b0); q_exp.push_back(V_MEMWR); end
        q_rdy.push_back(1'b1); q_exp.push_back(V_MEMWR);
      end
      T_BEQ: begin
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_BR);
      end
      default: begin
        q_rdy.push_back(1'($urandom)); q_exp.push_back(V_ILL);
        retires = 1'b0;
      end
    endcase
    opcode = op;
    zero   = z;
    n = (max_steps < q_exp.size()) ? max_steps : q_exp.size();
    for (int k = 0; k < n; k++) begin
      run_step(q_rdy[k], q_exp[k], $sformatf("txn%0d op=%b step%0d", txn, op, k));
    end
    if (retires && n == q_exp.size()) exp_instret++;
    $display("txn %0d op=%b fetch_wait=%0d mem_wait=%0d zero=%0b cycles=%0d/%0d",
             txn, op, fw, mw, z, n, q_exp.size());
    txn++;
  endtask

  // Called at a falling edge: holds rst across one rising edge, releases it
  // at the next falling edge so the following step is the first FETCH cycle.
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    mem_ready = rdy;
    #1;
    chk("rst_first_cycle/strobes", {16'd0, obs_vec}, 32'd0);
    @(negedge clk);
    chk("rst_held/strobes", {16'd0, obs_vec}, 32'd0);
    chk("rst_held/cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_held/instret_cnt", instret_cnt, 32'd0);
    rst = 1'b0;
    exp_cycles  = 0;
    exp_instret = 0;
    $display("txn %0d reset", txn);
    txn++;
  endtask

  function automatic logic [6:0] rand_illegal();
    logic [6:0] o;
    do o = 7'($urandom);
    while (o == T_R || o == T_I || o == T_LW || o == T_SW || o == T_BEQ);
    return o;
  endfunction

  initial begin
    logic [6:0] op;
    @(negedge clk);
    do_reset(1'b1);

    // Directed instructions.
    run_instr(T_R,   0, 0,  1'b0, 1000);
    run_instr(T_LW,  0, 3,  1'b0, 1000);
    run_instr(T_BEQ, 0, 0,  1'b1, 1000);
    run_instr(T_BEQ, 0, 0,  1'b0, 1000);
    run_instr(7'b1111111, 0, 0, 1'b0, 1000);
    run_instr(T_I,   2, 0,  1'b1, 1000);
    run_instr(T_SW,  1, 2,  1'b0, 1000);
    // Completion on the terminal wait cycle beats the timeout.
    run_instr(T_LW, 15, 15, 1'b0, 1000);
    run_instr(T_SW, 15, 15, 1'b1, 1000);

    // Randomized instruction mix.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = T_R;
        1: op = T_I;
        2: op = T_LW;
        3: op = T_SW;
        4: op = T_BEQ;
        default: op = rand_illegal();
      endcase
      run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom), 1000);
    end

    // Memory never answers in FETCH: 16 stalled cycles, then FAULT for good.
    opcode = T_R;
    for (int k = 0; k < 16; k++) run_step(1'b0, V_FWAIT, $sformatf("timeout fetch%0d", k));
    for (int k = 0; k < 5; k++)  run_step(1'($urandom), V_FAULT, $sformatf("fault hold%0d", k));
    $display("txn %0d fetch timeout into fault", txn);
    txn++;
    do_reset(1'b1);
    run_instr(T_BEQ, 0, 0, 1'b1, 1000);

    // Reset in the middle of a store wait: fetch, decode, address, 3 waits.
    run_instr(T_SW, 0, 8, 1'b0, 6);
    do_reset(1'b0);
    run_instr(T_R, 0, 0, 1'b0, 1000);
    run_instr(T_LW, 1, 1, 1'b0, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
